// File: rtl/visited_pkg.sv
// Shared types for the visited-bit controller: command opcodes, FSM states
// and the default node index width.
package visited_pkg;

    localparam int ADDR_WIDTH_DEF = 5;

    typedef enum logic [1:0] {
        OP_CLEAR = 2'd0,
        OP_MARK  = 2'd1,
        OP_QUERY = 2'd2,
        OP_SCAN  = 2'd3
    } cmd_op_e;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RD,
        WR,
        RSP,
        SCAN,
        DRAIN
    } state_e;

endpackage

// File: rtl/visited_ctrl_if.sv
// Command/response bundle of the visited-bit controller; the master issues
// commands, the slave (the controller) answers with one response per command.
interface visited_ctrl_if #(
    parameter int ADDR_WIDTH = visited_pkg::ADDR_WIDTH_DEF
) ();
    import visited_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    cmd_op_e               cmd_op;
    logic [ADDR_WIDTH-1:0] cmd_node;

    logic                  rsp_valid;
    logic                  rsp_hit;
    logic                  rsp_found;
    logic [ADDR_WIDTH-1:0] rsp_node;

    modport master (
        output cmd_valid, cmd_op, cmd_node,
        input  cmd_ready, rsp_valid, rsp_hit, rsp_found, rsp_node
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_node,
        output cmd_ready, rsp_valid, rsp_hit, rsp_found, rsp_node
    );

endinterface

// File: rtl/visited_ctrl.sv
// Visited-bit controller: CLEAR / MARK (test-and-set) / QUERY / SCAN over an
// external 1-bit dual-port RAM with registered, write-first outputs.
module visited_ctrl #(
    parameter int ADDR_WIDTH = visited_pkg::ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    visited_ctrl_if.slave         bus,
    output logic [ADDR_WIDTH-1:0] mem_addr_a,
    output logic [ADDR_WIDTH-1:0] mem_addr_b,
    output logic                  mem_data_a,
    output logic                  mem_data_b,
    output logic                  mem_we_a,
    output logic                  mem_we_b,
    input  logic                  mem_q_a,
    input  logic                  mem_q_b
);
    import visited_pkg::*;

    localparam int PW = ADDR_WIDTH - 1;
    localparam logic [PW-1:0] PAIR_LAST = '1;
    localparam logic [PW-1:0] PAIR_ONE  = {{(PW-1){1'b0}}, 1'b1};

    state_e                state, state_n;
    logic [PW-1:0]         pair, pair_n;
    cmd_op_e               op_r;
    logic [ADDR_WIDTH-1:0] node_r;

    logic                  rsp_valid_r, rsp_valid_n;
    logic                  rsp_hit_r, rsp_hit_n;
    logic                  rsp_found_r, rsp_found_n;
    logic [ADDR_WIDTH-1:0] rsp_node_r, rsp_node_n;

    // RAM data lags the address by one cycle, so SCAN evaluates the previous
    // pair; in DRAIN the counter has stopped on the last pair.
    logic [PW-1:0]         eval_pair;
    logic                  scan_zero;
    logic [ADDR_WIDTH-1:0] zero_node;

    assign eval_pair = (state == DRAIN) ? pair : pair - PAIR_ONE;
    assign scan_zero = !mem_q_a || !mem_q_b;
    assign zero_node = {eval_pair, mem_q_a};

    assign bus.cmd_ready = (state == IDLE);
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_hit   = rsp_hit_r;
    assign bus.rsp_found = rsp_found_r;
    assign bus.rsp_node  = rsp_node_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rsp_valid_r <= 1'b0;
            rsp_hit_r   <= 1'b0;
            rsp_found_r <= 1'b0;
            rsp_node_r  <= '0;
        end else begin
            state       <= state_n;
            rsp_valid_r <= rsp_valid_n;
            rsp_hit_r   <= rsp_hit_n;
            rsp_found_r <= rsp_found_n;
            rsp_node_r  <= rsp_node_n;
        end
    end

    always_ff @(posedge clk) begin
        pair <= pair_n;
        if (state == IDLE && bus.cmd_valid) begin
            op_r   <= bus.cmd_op;
            node_r <= bus.cmd_node;
        end
    end

    always_comb begin
        state_n     = state;
        pair_n      = pair;
        rsp_valid_n = 1'b0;
        rsp_hit_n   = 1'b0;
        rsp_found_n = 1'b0;
        rsp_node_n  = '0;
        mem_addr_a  = '0;
        mem_addr_b  = '0;
        mem_data_a  = 1'b0;
        mem_data_b  = 1'b0;
        mem_we_a    = 1'b0;
        mem_we_b    = 1'b0;

        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    pair_n = '0;
                    case (bus.cmd_op)
                        OP_CLEAR: state_n = CLEAR;
                        OP_SCAN:  state_n = SCAN;
                        default:  state_n = RD;
                    endcase
                end
            end
            CLEAR: begin
                mem_addr_a = {pair, 1'b0};
                mem_addr_b = {pair, 1'b1};
                mem_we_a   = 1'b1;
                mem_we_b   = 1'b1;
                if (pair == PAIR_LAST) begin
                    rsp_valid_n = 1'b1;
                    state_n     = IDLE;
                end else begin
                    pair_n = pair + PAIR_ONE;
                end
            end
            RD: begin
                mem_addr_a = node_r;
                state_n    = (op_r == OP_MARK) ? WR : RSP;
            end
            WR: begin
                mem_addr_a  = node_r;
                mem_data_a  = 1'b1;
                mem_we_a    = 1'b1;
                rsp_valid_n = 1'b1;
                rsp_hit_n   = mem_q_a;
                rsp_node_n  = node_r;
                state_n     = IDLE;
            end
            RSP: begin
                rsp_valid_n = 1'b1;
                rsp_hit_n   = mem_q_a;
                rsp_node_n  = node_r;
                state_n     = IDLE;
            end
            SCAN: begin
                mem_addr_a = {pair, 1'b0};
                mem_addr_b = {pair, 1'b1};
                if (pair != '0 && scan_zero) begin
                    rsp_valid_n = 1'b1;
                    rsp_found_n = 1'b1;
                    rsp_node_n  = zero_node;
                    state_n     = IDLE;
                end else if (pair == PAIR_LAST) begin
                    state_n = DRAIN;
                end else begin
                    pair_n = pair + PAIR_ONE;
                end
            end
            DRAIN: begin
                rsp_valid_n = 1'b1;
                rsp_found_n = scan_zero;
                rsp_node_n  = scan_zero ? zero_node : '0;
                state_n     = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_visited_ctrl.sv
// Bench for visited_ctrl: a behavioural RAM plus a visited-set model predict
// every response value and its latency.
module tb_visited_ctrl;
    import visited_pkg::*;

    localparam int AW = 5;
    localparam int N  = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] mem_addr_a, mem_addr_b;
    logic          mem_data_a, mem_data_b, mem_we_a, mem_we_b;
    logic          mem_q_a = 1'b0;
    logic          mem_q_b = 1'b0;

    int tests = 0;
    int fails = 0;
    int we_cnt = 0;
    int rsp_cnt = 0;

    logic ram [N];
    bit   model [N];

    visited_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    visited_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .mem_addr_a (mem_addr_a),
        .mem_addr_b (mem_addr_b),
        .mem_data_a (mem_data_a),
        .mem_data_b (mem_data_b),
        .mem_we_a   (mem_we_a),
        .mem_we_b   (mem_we_b),
        .mem_q_a    (mem_q_a),
        .mem_q_b    (mem_q_b)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (mem_we_a) ram[mem_addr_a] <= mem_data_a;
        if (mem_we_b) ram[mem_addr_b] <= mem_data_b;
        mem_q_a <= mem_we_a ? mem_data_a : ram[mem_addr_a];
        mem_q_b <= mem_we_b ? mem_data_b : ram[mem_addr_b];
        if (mem_we_a || mem_we_b) we_cnt <= we_cnt + 1;
        if (bus.rsp_valid) rsp_cnt <= rsp_cnt + 1;
    end

    function automatic int first_zero();
        for (int i = 0; i < N; i++)
            if (!model[i]) return i;
        return -1;
    endfunction

    // Drives one command, waits for its response; lat counts cycles from the
    // acceptance cycle T (rsp seen in T+lat), -1 on timeout.
    task automatic issue(input cmd_op_e op, input logic [AW-1:0] node,
                         output int lat, output logic hit, output logic found,
                         output logic [AW-1:0] rnode);
        int guard = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_node  = node;
        while (!bus.cmd_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        hit = bus.rsp_hit; found = bus.rsp_found; rnode = bus.rsp_node;
        if (!bus.rsp_valid) lat = -1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_hit, bus.rsp_found, bus.rsp_node} !== {1'b1, 8'h0}) begin
            fails++;
            $display("FAIL reset_rsp: ready/valid/hit/found/node=%b required 1_0000_0000",
                     {bus.cmd_ready, bus.rsp_valid, bus.rsp_hit, bus.rsp_found, bus.rsp_node});
        end
        tests++;
        if ({mem_we_a, mem_we_b, mem_data_a, mem_data_b, mem_addr_a, mem_addr_b} !== 14'h0) begin
            fails++;
            $display("FAIL reset_mem: mem outputs=%h required 0",
                     {mem_we_a, mem_we_b, mem_data_a, mem_data_b, mem_addr_a, mem_addr_b});
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_clear_held_valid();
        int we0 = we_cnt;
        logic [13:0] exp_v, got_v;
        bus.cmd_valid = 1'b1; bus.cmd_op = OP_CLEAR; bus.cmd_node = '0;
        @(posedge clk); #1;
        bus.cmd_op = OP_MARK; bus.cmd_node = 5'd9;
        for (int k = 0; k < 16; k++) begin
            exp_v = {1'b1, 1'b1, 1'b0, 1'b0, 5'(2 * k), 5'(2 * k + 1)};
            got_v = {mem_we_a, mem_we_b, mem_data_a, mem_data_b, mem_addr_a, mem_addr_b};
            tests++;
            if (got_v !== exp_v || bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b0) begin
                fails++;
                $display("FAIL clear_pair%0d: mem=%h ready=%b rsp=%b required mem=%h ready=0 rsp=0",
                         k, got_v, bus.cmd_ready, bus.rsp_valid, exp_v);
            end
            if (k == 15) bus.cmd_valid = 1'b0;
            @(posedge clk); #1;
        end
        tests++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_node !== 5'd0 || bus.rsp_hit !== 1'b0 || bus.rsp_found !== 1'b0) begin
            fails++;
            $display("FAIL clear_rsp_T17: valid=%b hit=%b found=%b node=%0d required 1 0 0 0",
                     bus.rsp_valid, bus.rsp_hit, bus.rsp_found, bus.rsp_node);
        end
        @(posedge clk); #1;
        tests++;
        if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || we_cnt - we0 !== 16) begin
            fails++;
            $display("FAIL clear_after: valid=%b ready=%b writes=%0d required 0 1 16",
                     bus.rsp_valid, bus.cmd_ready, we_cnt - we0);
        end
        for (int i = 0; i < N; i++) model[i] = 1'b0;
    endtask

    task automatic test_mark();
        int lat; logic hit, found; logic [AW-1:0] rn;
        for (int r = 0; r < 2; r++) begin
            issue(OP_MARK, 5'd7, lat, hit, found, rn);
            tests++;
            if (lat !== 3 || hit !== model[7] || found !== 1'b0 || rn !== 5'd7) begin
                fails++;
                $display("FAIL mark7_%0d: lat=%0d hit=%b found=%b node=%0d required 3 %b 0 7",
                         r, lat, hit, found, rn, model[7]);
            end
            model[7] = 1'b1;
            @(posedge clk); #1;
            tests++;
            if (bus.rsp_valid !== 1'b0) begin
                fails++;
                $display("FAIL mark_pulse_%0d: rsp_valid=%b required 0", r, bus.rsp_valid);
            end
        end
    endtask

    task automatic test_query();
        int lat; logic hit, found; logic [AW-1:0] rn;
        int we0 = we_cnt;
        issue(OP_QUERY, 5'd7, lat, hit, found, rn);
        tests++;
        if (lat !== 3 || hit !== 1'b1 || found !== 1'b0 || rn !== 5'd7) begin
            fails++;
            $display("FAIL query7: lat=%0d hit=%b found=%b node=%0d required 3 1 0 7", lat, hit, found, rn);
        end
        issue(OP_QUERY, 5'd8, lat, hit, found, rn);
        tests++;
        if (lat !== 3 || hit !== 1'b0 || rn !== 5'd8) begin
            fails++;
            $display("FAIL query8: lat=%0d hit=%b node=%0d required 3 0 8", lat, hit, rn);
        end
        tests++;
        if (we_cnt !== we0) begin
            fails++;
            $display("FAIL query_nowrite: writes=%0d required 0", we_cnt - we0);
        end
    endtask

    task automatic test_scan_hit();
        int lat; logic hit, found; logic [AW-1:0] rn;
        int we0;
        for (int i = 0; i < 3; i++) begin
            issue(OP_MARK, 5'(i), lat, hit, found, rn);
            model[i] = 1'b1;
        end
        we0 = we_cnt;
        issue(OP_SCAN, 5'd0, lat, hit, found, rn);
        tests++;
        if (lat !== 4 || found !== 1'b1 || rn !== 5'd3 || hit !== 1'b0) begin
            fails++;
            $display("FAIL scan_hit: lat=%0d found=%b node=%0d hit=%b required 4 1 3 0", lat, found, rn, hit);
        end
        tests++;
        if (we_cnt !== we0) begin
            fails++;
            $display("FAIL scan_nowrite: writes=%0d required 0", we_cnt - we0);
        end
    endtask

    task automatic test_scan_full();
        int lat; logic hit, found; logic [AW-1:0] rn;
        int bad = 0;
        for (int i = 0; i < N; i++) begin
            issue(OP_MARK, 5'(i), lat, hit, found, rn);
            if (lat !== 3 || hit !== model[i] || rn !== 5'(i)) bad++;
            model[i] = 1'b1;
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL mark_all: bad responses=%0d required 0", bad);
        end
        issue(OP_SCAN, 5'd0, lat, hit, found, rn);
        tests++;
        if (lat !== 18 || found !== 1'b0 || rn !== 5'd0) begin
            fails++;
            $display("FAIL scan_full: lat=%0d found=%b node=%0d required 18 0 0", lat, found, rn);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic hit, found; logic [AW-1:0] rn;
        issue(OP_CLEAR, 5'd0, lat, hit, found, rn);
        for (int i = 0; i < N; i++) model[i] = 1'b0;
        tests++;
        if (lat !== 17 || bus.cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL b2b_clear: lat=%0d ready=%b required 17 1", lat, bus.cmd_ready);
        end
        issue(OP_MARK, 5'd5, lat, hit, found, rn);
        model[5] = 1'b1;
        tests++;
        if (lat !== 3 || hit !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL b2b_mark: lat=%0d hit=%b ready=%b required 3 0 1", lat, hit, bus.cmd_ready);
        end
        issue(OP_QUERY, 5'd5, lat, hit, found, rn);
        tests++;
        if (lat !== 3 || hit !== 1'b1 || rn !== 5'd5) begin
            fails++;
            $display("FAIL b2b_query: lat=%0d hit=%b node=%0d required 3 1 5", lat, hit, rn);
        end
    endtask

    task automatic test_reset_abort();
        int lat; logic hit, found; logic [AW-1:0] rn;
        int rsp0;
        bus.cmd_valid = 1'b1; bus.cmd_op = OP_CLEAR; bus.cmd_node = '0;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        tests++;
        if (mem_addr_a !== 5'd10 || mem_we_a !== 1'b1) begin
            fails++;
            $display("FAIL abort_pair5: addr_a=%0d we_a=%b required 10 1", mem_addr_a, mem_we_a);
        end
        rsp0 = rsp_cnt;
        reset = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || mem_we_a !== 1'b0 || mem_we_b !== 1'b0) begin
            fails++;
            $display("FAIL abort_idle: ready=%b rsp=%b we=%b%b required 1 0 00",
                     bus.cmd_ready, bus.rsp_valid, mem_we_a, mem_we_b);
        end
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        tests++;
        if (rsp_cnt !== rsp0) begin
            fails++;
            $display("FAIL abort_norsp: responses=%0d required 0", rsp_cnt - rsp0);
        end
        issue(OP_CLEAR, 5'd0, lat, hit, found, rn);
        for (int i = 0; i < N; i++) model[i] = 1'b0;
        tests++;
        if (lat !== 17) begin
            fails++;
            $display("FAIL abort_reclear: lat=%0d required 17", lat);
        end
    endtask

    task automatic test_random();
        int lat, elat, z, sel;
        logic hit, found, ehit, efound;
        logic [AW-1:0] rn, en, node;
        cmd_op_e op;
        for (int t = 0; t < 120; t++) begin
            sel  = int'($urandom_range(0, 99));
            node = 5'($urandom_range(0, N - 1));
            op   = (sel < 3) ? OP_CLEAR : (sel < 60) ? OP_MARK : (sel < 80) ? OP_QUERY : OP_SCAN;
            ehit = 1'b0; efound = 1'b0; en = '0;
            case (op)
                OP_CLEAR: elat = 17;
                OP_SCAN: begin
                    z = first_zero();
                    if (z < 0) elat = 18;
                    else begin elat = 3 + z / 2; efound = 1'b1; en = 5'(z); end
                end
                default: begin elat = 3; ehit = model[node]; en = node; end
            endcase
            issue(op, node, lat, hit, found, rn);
            tests++;
            if (lat !== elat || hit !== ehit || found !== efound || rn !== en) begin
                fails++;
                $display("FAIL rand%0d op=%0d n=%0d: lat=%0d hit=%b found=%b node=%0d required %0d %b %b %0d",
                         t, op, node, lat, hit, found, rn, elat, ehit, efound, en);
            end
            if (op == OP_CLEAR) for (int i = 0; i < N; i++) model[i] = 1'b0;
            if (op == OP_MARK) model[node] = 1'b1;
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_CLEAR;
        bus.cmd_node  = '0;
        test_reset();
        test_clear_held_valid();
        test_mark();
        test_query();
        test_scan_hit();
        test_scan_full();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
